// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, the rectangle slot record and the scan-length helper.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Slot fields are sized for the widest supported build; narrower ports zero-extend.
    localparam int unsigned RECT_COORD_W = 16;
    localparam int unsigned RECT_RGB_W   = 24;

    typedef struct packed {
        logic [RECT_COORD_W-1:0] x;
        logic [RECT_COORD_W-1:0] y;
        logic [RECT_COORD_W-1:0] w;
        logic [RECT_COORD_W-1:0] h;
        logic [RECT_RGB_W-1:0]   rgb;
        logic                    en;
    } rect_t;

    function automatic int unsigned scan_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster scan counters with raw (active-high) sync flags, active-area flag and
// a look-ahead flag that is true when the next cycle is the bank commit cycle.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned COORD_W  = 11
) (
    input  logic               pixel_clk,
    input  logic               reset,
    output logic [COORD_W-1:0] h,
    output logic [COORD_W-1:0] v,
    output logic               active,
    output logic               hs_on,
    output logic               vs_on,
    output logic               commit_next
);

    localparam int unsigned H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        h_d = h_q + COORD_W'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + COORD_W'(1);
        end
    end

    assign h           = h_q;
    assign v           = v_q;
    assign active      = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_on       = (h_q >= HS_START) && (h_q < HS_END);
    assign vs_on       = (v_q >= VS_START) && (v_q < VS_END);
    assign commit_next = (h_d == '0) && (v_d == V_ACT);

endmodule

// File: rtl/vga_rect_renderer.sv
// Draws up to N_RECT solid rectangles over a background colour; slots are written into
// a shadow bank and copied to the live bank once per frame, just after the active area.
module vga_rect_renderer
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned N_RECT   = 4,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned COORD_W  = 11,
    parameter bit          SYNC_POL = 1'b0,
    localparam int unsigned IDX_W   = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
    input  logic                   pixel_clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [COORD_W-1:0]     wr_x,
    input  logic [COORD_W-1:0]     wr_y,
    input  logic [COORD_W-1:0]     wr_w,
    input  logic [COORD_W-1:0]     wr_h,
    input  logic [3*COLOR_W-1:0]   wr_rgb,
    input  logic                   wr_en,
    input  logic [3*COLOR_W-1:0]   bg_rgb,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   frame_start
);

    localparam int unsigned RGB_W = 3 * COLOR_W;
    localparam int unsigned SUM_W = RECT_COORD_W + 1;

    logic [COORD_W-1:0] h, v;
    logic               active, hs_on, vs_on, commit_next;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .COORD_W  (COORD_W)
    ) u_timing (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .h           (h),
        .v           (v),
        .active      (active),
        .hs_on       (hs_on),
        .vs_on       (vs_on),
        .commit_next (commit_next)
    );

    // Commit status is registered one cycle early so wr_ready/frame_start are flop outputs.
    logic frame_start_q, wr_ready_q;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            frame_start_q <= 1'b0;
            wr_ready_q    <= 1'b1;
        end else begin
            frame_start_q <= commit_next;
            wr_ready_q    <= !commit_next;
        end
    end

    assign frame_start = frame_start_q;
    assign wr_ready    = wr_ready_q;

    rect_t shadow_q [N_RECT];
    rect_t live_q   [N_RECT];

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            for (int i = 0; i < N_RECT; i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
            end
        end else begin
            if (frame_start_q) begin
                for (int i = 0; i < N_RECT; i++) begin
                    live_q[i] <= shadow_q[i];
                end
            end
            if (wr_valid && wr_ready_q) begin
                shadow_q[wr_idx] <= '{x:   RECT_COORD_W'(wr_x),
                                      y:   RECT_COORD_W'(wr_y),
                                      w:   RECT_COORD_W'(wr_w),
                                      h:   RECT_COORD_W'(wr_h),
                                      rgb: RECT_RGB_W'(wr_rgb),
                                      en:  wr_en};
            end
        end
    end

    // One bit wider than the slot fields so x+w never wraps back over the origin.
    function automatic logic rect_hit(input rect_t r, input logic [SUM_W-1:0] px,
                                      input logic [SUM_W-1:0] py);
        logic [SUM_W-1:0] x0, x1, y0, y1;
        x0 = {1'b0, r.x};
        x1 = {1'b0, r.x} + {1'b0, r.w};
        y0 = {1'b0, r.y};
        y1 = {1'b0, r.y} + {1'b0, r.h};
        return r.en && (px >= x0) && (px < x1) && (py >= y0) && (py < y1);
    endfunction

    logic [SUM_W-1:0] h_ext, v_ext;
    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;

    assign h_ext = SUM_W'(h);
    assign v_ext = SUM_W'(v);

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        // Scan downward so the lowest-index hit is the one left standing.
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (rect_hit(live_q[i], h_ext, v_ext)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    logic             s1_active, s1_hs, s1_vs, s1_hit;
    logic [IDX_W-1:0] s1_idx;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            s1_active <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_hit    <= 1'b0;
            s1_idx    <= '0;
        end else begin
            s1_active <= active;
            s1_hs     <= hs_on;
            s1_vs     <= vs_on;
            s1_hit    <= hit_any;
            s1_idx    <= hit_idx;
        end
    end

    logic [RGB_W-1:0] color_d;

    always_comb begin
        color_d = '0;
        if (s1_active) begin
            color_d = s1_hit ? live_q[s1_idx].rgb[RGB_W-1:0] : bg_rgb;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= !SYNC_POL;
            vga_vs <= !SYNC_POL;
        end else begin
            vga_r  <= color_d[RGB_W-1 -: COLOR_W];
            vga_g  <= color_d[2*COLOR_W-1 -: COLOR_W];
            vga_b  <= color_d[COLOR_W-1:0];
            vga_hs <= s1_hs ? SYNC_POL : !SYNC_POL;
            vga_vs <= s1_vs ? SYNC_POL : !SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_rect_renderer.sv
// Self-checking bench: every output cycle is compared against a pixel-level reference
// model of the scan, with directed rectangle scenarios plus randomized slot contents.
module tb_vga_rect_renderer;

    // Reduced raster so many whole frames fit in a short run.
    localparam int HA = 64, HF = 4, HSW = 12, HB = 8;
    localparam int VA = 24, VF = 2, VSW = 3, VB = 3;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam int NR = 4, CW = 4, XW = 11, RGBW = 3 * CW;
    localparam bit POL = 1'b0;

    logic            pixel_clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [1:0]      wr_idx = '0;
    logic [XW-1:0]   wr_x = '0, wr_y = '0, wr_w = '0, wr_h = '0;
    logic [RGBW-1:0] wr_rgb = '0;
    logic            wr_en = 1'b0;
    logic [RGBW-1:0] bg_rgb = '0;
    logic [CW-1:0]   vga_r, vga_g, vga_b;
    logic            vga_hs, vga_vs, frame_start;

    always #5 pixel_clk = ~pixel_clk;

    vga_rect_renderer #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
        .N_RECT (NR), .COLOR_W (CW), .COORD_W (XW), .SYNC_POL (POL)
    ) dut (
        .pixel_clk (pixel_clk), .reset (reset),
        .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_idx (wr_idx),
        .wr_x (wr_x), .wr_y (wr_y), .wr_w (wr_w), .wr_h (wr_h),
        .wr_rgb (wr_rgb), .wr_en (wr_en), .bg_rgb (bg_rgb),
        .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
        .vga_hs (vga_hs), .vga_vs (vga_vs), .frame_start (frame_start)
    );

    typedef struct {
        int              x, y, w, h;
        logic [RGBW-1:0] rgb;
        bit              en;
    } mrect_t;

    mrect_t shadow_m [NR];
    mrect_t live_m   [NR];
    int     cyc = 0, base = 0, checks = 0, failures = 0;

    function automatic bit is_commit(int n);
        return ((n % HT) == 0) && (((n / HT) % VT) == VA);
    endfunction

    function automatic logic [RGBW-1:0] pix(int ph, int pv);
        if (!(ph < HA && pv < VA)) return '0;
        for (int i = 0; i < NR; i++) begin
            if (live_m[i].en && ph >= live_m[i].x && ph < live_m[i].x + live_m[i].w &&
                pv >= live_m[i].y && pv < live_m[i].y + live_m[i].h) return live_m[i].rgb;
        end
        return bg_rgb;
    endfunction

    // n counts cycles since the scan restarted at (0,0); pixels surface two cycles later.
    function automatic logic [RGBW+3:0] expected(int n);
        logic [RGBW-1:0] c;
        bit hs, vs;
        int p, ph, pv;
        if (n < 2) begin
            c = '0; hs = !POL; vs = !POL;
        end else begin
            p  = n - 2;
            ph = p % HT;
            pv = (p / HT) % VT;
            c  = pix(ph, pv);
            hs = (ph >= HA + HF && ph < HA + HF + HSW) ? POL : !POL;
            vs = (pv >= VA + VF && pv < VA + VF + VSW) ? POL : !POL;
        end
        return {c, hs, vs, is_commit(n), !is_commit(n)};
    endfunction

    task automatic check_outputs();
        logic [RGBW+3:0] obs, exp;
        obs = {vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, wr_ready};
        exp = expected(cyc - base);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL scan n=%0d observed=%h expected=%h", cyc - base, obs, exp);
        end
    endtask

    // Apply this cycle's effects to the model, advance one clock, then compare.
    task automatic step();
        int n;
        n = cyc - base;
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                shadow_m[i].en = 1'b0;
                live_m[i].en   = 1'b0;
            end
        end else if (is_commit(n)) begin
            live_m = shadow_m;
        end else if (wr_valid) begin
            shadow_m[wr_idx] = '{x: int'(wr_x), y: int'(wr_y), w: int'(wr_w), h: int'(wr_h),
                                 rgb: wr_rgb, en: wr_en};
        end
        @(posedge pixel_clk);
        #1;
        cyc++;
        if (reset) base = cyc;
        check_outputs();
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic bound_check(string tag, bit ok);
        checks++;
        assert (ok) else begin
            failures++;
            $error("FAIL %s observed=timeout required=reached", tag);
        end
    endtask

    // Step until the scan counter itself sits at (ph, pv).
    task automatic goto_pos(int ph, int pv);
        bit found = 1'b0;
        for (int k = 0; k < FRAME + 8 && !found; k++) begin
            step();
            if (((cyc - base) % FRAME) == pv * HT + ph) found = 1'b1;
        end
        bound_check("goto_pos", found);
    endtask

    // Step until the output shows pixel (ph, pv).
    task automatic goto_pixel(int ph, int pv);
        bit found = 1'b0;
        for (int k = 0; k < FRAME + 8 && !found; k++) begin
            step();
            if ((cyc - base) >= 2 && ((cyc - base - 2) % FRAME) == pv * HT + ph) found = 1'b1;
        end
        bound_check("goto_pixel", found);
    endtask

    task automatic wait_commit();
        goto_pos(0, VA);
    endtask

    task automatic check_pix(string tag, logic [RGBW-1:0] exp);
        checks++;
        assert ({vga_r, vga_g, vga_b} === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, {vga_r, vga_g, vga_b}, exp);
        end
    endtask

    task automatic check_val(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_slot(int idx, int x, int y, int w, int h, logic [RGBW-1:0] rgb,
                              bit en, output int lat);
        bit done = 1'b0;
        wr_valid = 1'b1;
        wr_idx = 2'(idx);
        wr_x = XW'(x); wr_y = XW'(y); wr_w = XW'(w); wr_h = XW'(h);
        wr_rgb = rgb; wr_en = en;
        lat = 0;
        for (int k = 0; k < 4 && !done; k++) begin
            done = !is_commit(cyc - base);
            step();
            lat++;
        end
        wr_valid = 1'b0;
        bound_check("write_accept", done);
    endtask

    initial begin
        int lat, hs_cnt, vs_cnt, fs_cnt, k;
        bit seen;
        for (int i = 0; i < NR; i++) begin
            shadow_m[i] = '{x: 0, y: 0, w: 0, h: 0, rgb: '0, en: 1'b0};
            live_m[i]   = shadow_m[i];
        end
        bg_rgb = {4'($urandom_range(1, 14)), 4'($urandom), 4'($urandom)};

        // Reset state
        reset = 1'b1;
        run(3);
        check_pix("reset_rgb", '0);
        check_val("reset_sync_fs_rdy", int'({vga_hs, vga_vs, frame_start, wr_ready}),
                  int'({!POL, !POL, 1'b0, 1'b1}));
        reset = 1'b0;

        // Free-running timing over one whole frame
        run(2);
        hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (vga_hs == POL) hs_cnt++;
            if (vga_vs == POL) vs_cnt++;
            if (frame_start) fs_cnt++;
        end
        check_val("hs_active_cycles", hs_cnt, HSW * VT);
        check_val("vs_active_cycles", vs_cnt, VSW * HT);
        check_val("frame_start_pulses", fs_cnt, 1);

        // Single rectangle and two-cycle latency
        write_slot(0, 20, 5, 10, 4, 12'hF00, 1'b1, lat);
        wait_commit();
        goto_pos(20, 5);
        step();
        check_pix("rect_left_of_x", bg_rgb);
        step();
        check_pix("rect_first_px", 12'hF00);
        goto_pixel(30, 5);
        check_pix("rect_right_edge", bg_rgb);
        goto_pixel(29, 8);
        check_pix("rect_last_px", 12'hF00);
        goto_pixel(20, 9);
        check_pix("rect_below", bg_rgb);

        // Mid-frame move is held back until the next commit
        goto_pos(0, 6);
        write_slot(0, 40, 5, 10, 4, 12'hF00, 1'b1, lat);
        goto_pixel(25, 7);
        check_pix("old_x_this_frame", 12'hF00);
        goto_pixel(45, 7);
        check_pix("new_x_not_yet", bg_rgb);
        wait_commit();
        goto_pixel(25, 7);
        check_pix("old_x_after_commit", bg_rgb);
        goto_pixel(45, 7);
        check_pix("new_x_after_commit", 12'hF00);

        // Write presented in the commit cycle waits one cycle
        wait_commit();
        check_val("commit_ready_low", int'(wr_ready), 0);
        write_slot(2, 2047, 0, 2047, 2047, 12'h0FF, 1'b1, lat);
        check_val("commit_write_latency", lat, 2);

        // Overlap priority
        write_slot(0, 10, 10, 20, 20, 12'h0F0, 1'b1, lat);
        write_slot(1, 0, 0, 40, 40, 12'h00F, 1'b1, lat);
        wait_commit();
        goto_pixel(5, 5);
        check_pix("overlap_low_only", 12'h00F);
        goto_pixel(15, 15);
        check_pix("overlap_priority", 12'h0F0);

        // Clipping and degenerate slots
        write_slot(0, HA - 10, 2, 50, 3, 12'hF0F, 1'b1, lat);
        write_slot(1, 0, 0, 0, 10, 12'hFF0, 1'b1, lat);
        write_slot(3, 0, 0, HA, VA, 12'hFFF, 1'b0, lat);
        wait_commit();
        goto_pixel(0, 0);
        check_pix("wrap_and_zero_w", bg_rgb);
        goto_pixel(HA - 11, 2);
        check_pix("clip_left_of_x", bg_rgb);
        step();
        check_pix("clip_first_px", 12'hF0F);
        goto_pixel(HA - 1, 2);
        check_pix("clip_last_px", 12'hF0F);
        step();
        check_pix("clip_porch_blank", '0);

        // Randomized slot contents and write timing, checked frame by frame
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < NR; s++) begin
                write_slot(s, int'($urandom_range(0, HA + 8)), int'($urandom_range(0, VA + 4)),
                           int'($urandom_range(0, 40)), int'($urandom_range(0, 16)),
                           RGBW'($urandom), ($urandom_range(0, 3) != 0), lat);
                run(int'($urandom_range(0, 50)));
            end
            wait_commit();
            run(FRAME);
        end

        // Mid-frame reset with a simultaneous write that must be dropped
        goto_pos(30, 10);
        reset = 1'b1;
        wr_valid = 1'b1; wr_idx = 2'd0;
        wr_x = '0; wr_y = '0; wr_w = XW'(HA); wr_h = XW'(VA);
        wr_rgb = 12'hFFF; wr_en = 1'b1;
        step();
        reset = 1'b0;
        wr_valid = 1'b0;
        check_pix("midreset_rgb", '0);
        check_val("midreset_sync_fs_rdy", int'({vga_hs, vga_vs, frame_start, wr_ready}),
                  int'({!POL, !POL, 1'b0, 1'b1}));
        k = 0;
        seen = 1'b0;
        while (!seen && k < HT + 4) begin
            step();
            k++;
            if (vga_hs == POL) seen = 1'b1;
        end
        check_val("restart_first_hsync", k, HA + HF + 2);
        wait_commit();
        goto_pixel(5, 5);
        check_pix("slots_cleared", bg_rgb);
        run(FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_rect_renderer.md
VGA_RECT_RENDERER -- requirements
Module: vga_rect_renderer

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_ACTIVE 640 visible columns; H_FP 16, H_SYNC 96, H_BP 48 horizontal porch/sync in pixels; V_ACTIVE 480 visible rows; V_FP 10, V_SYNC 2, V_BP 33 vertical porch/sync in lines; N_RECT 4 rectangle slots; COLOR_W 4 bits per channel; COORD_W 11 coordinate width; SYNC_POL 0 sync active level.
REQ-002 SHALL use one clock and a synchronous, active-high reset: pixel_clk (input, 1, pixel clock) and reset (input, 1, synchronous active-high reset).
REQ-003 SHALL have write ports (all inputs except wr_ready): wr_valid 1, write request; wr_ready output 1, write accepted; wr_idx clog2(N_RECT), slot index; wr_x/wr_y COORD_W, top-left corner; wr_w/wr_h COORD_W, size; wr_rgb 3*COLOR_W, {R,G,B}; wr_en 1, slot visible.
REQ-004 SHALL have bg_rgb input, 3*COLOR_W, background colour.
REQ-005 SHALL have outputs vga_r/vga_g/vga_b COLOR_W, colour; vga_hs/vga_vs 1, syncs; frame_start 1, one-cycle pulse when the shadow bank is committed.

Function
REQ-006 SHALL count h from 0 to H_TOTAL-1 (H_TOTAL = sum of horizontal parameters), then wrap to 0 and advance v, which wraps 0..V_TOTAL-1.
REQ-007 SHALL assert hs while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC and vs by the same rule on v; asserted level = SYNC_POL.
REQ-008 SHALL treat a pixel as active when h < H_ACTIVE and v < V_ACTIVE.
REQ-009 SHALL hold two register banks per slot, shadow and live; writes go only to shadow.
REQ-010 SHALL accept a write when wr_valid && wr_ready; wr_ready SHALL be 1 in every cycle except the commit cycle.
REQ-011 SHALL commit (copy all shadow slots to live) in the cycle where h==0 and v==V_ACTIVE, and SHALL pulse frame_start in that cycle.
REQ-012 SHALL treat a write presented during the commit cycle as not accepted; the writer holds it until a later accepted cycle.
REQ-013 SHALL count slot i as a hit when live enable=1, x <= h < x+w and y <= v < y+h; the sums use COORD_W+1 bits, so there is no wrap.
REQ-014 SHALL make w==0 or h==0 invisible, and SHALL clip rectangles extending beyond the active area, drawing only the visible part.
REQ-015 SHALL give priority to the lowest-index hit slot; with no hit, colour = bg_rgb; for inactive pixels, colour = 0.
REQ-016 SHALL have a 2-cycle pipeline (hit stage, colour-mux stage); hs/vs SHALL be delayed 2 cycles so colour and sync stay aligned.
REQ-017 SHALL register all outputs, with no combinational path from any input to any output.
REQ-018 SHALL take rendering only from the live bank, so a frame never shows a partially updated set.

Reset
REQ-019 SHALL, while reset is high at a pixel_clk edge, set h=v=0, clear all shadow and live enables, set vga_r/g/b=0, set hs/vs to the inactive level (!SYNC_POL) including pipeline stages, set frame_start=0 and wr_ready=1.
REQ-020 SHALL drop a write presented in a reset cycle.
REQ-021 SHALL, when reset is asserted mid-frame, restart the scan at h=v=0 on the next cycle with no commit.

Structure
REQ-022 SHALL have a shared package vga_pkg holding the default timing constants, the rect_t type (x, y, w, h, rgb, en) and the H_TOTAL/V_TOTAL derivation function.
REQ-023 SHALL have one sub-module, vga_timing_gen (counters, raw syncs, active flag); the renderer instantiates it and adds the banks, hit logic and pipeline.

Verification
REQ-024 SHALL check free-run timing with defaults: hs period 800 clocks, low for 96, first low at h=656; vs period 525 lines, low for 2 lines starting at v=490.
REQ-025 SHALL check a single rect: slot0 x=100, y=50, w=10, h=4, rgb=F00, en=1, written, then one commit. Next frame: pixels (100..109, 50..53) = F00, (110,50) and (100,54) = bg_rgb, colour appears 2 cycles after the counter value.
REQ-026 SHALL check overlap: slot0 (10,10,20,20) 0F0 and slot1 (0,0,40,40) 00F; (15,15)=0F0 and (5,5)=00F.
REQ-027 SHALL check commit boundary: a write to slot0 moving x 100->200 issued mid-frame leaves the current frame at x=100 and shows x=200 after frame_start; a write held in the commit cycle sees wr_ready=0 and is accepted next cycle.
REQ-028 SHALL check clip and degenerate cases: slot x=630, w=50 draws only h 630..639 with blank porch; w=0 draws nothing; x=2047, w=2047 causes no wrap artefact at h=0.
REQ-029 SHALL check reset at h=300, v=200: the next cycle has outputs 0, syncs inactive, all slots disabled; the scan restarts at (0,0).
